mem_stage_sized: RTL and testbench

- Parametrised successor of the pipeline MEM stage. Sits between the EX/MEM and MEM/WB pipeline registers.
- Holds the data memory and supports byte, halfword, word and (when DATA_W=64) doubleword loads and stores, with sign or zero extension on loads.
- Supports a configurable multi-cycle memory latency, with a stall output to the hazard unit.
- Detects misaligned accesses and registers all results into the MEM/WB register.

---
 rtl/mem_stage_sized.sv | 180 ++++++++++++++++++
 tb/tb_mem_stage_sized.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sized.sv
// Pipeline MEM stage: data memory with sized, extended loads and byte-enabled stores,
// optional multi-cycle access latency and misalignment detection, feeding MEM/WB.
module mem_stage_sized #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned MEM_LATENCY = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  EX_MEM_Valid,
  input  logic [DATA_W-1:0]     EX_MEM_ALUResult,
  input  logic [DATA_W-1:0]     EX_MEM_ReadData2,
  input  logic [REG_ADDR_W-1:0] EX_MEM_WriteReg,
  input  logic                  EX_MEM_MemRead,
  input  logic                  EX_MEM_MemWrite,
  input  logic [1:0]            EX_MEM_Size,
  input  logic                  EX_MEM_Unsigned,
  input  logic                  EX_MEM_MemToReg,
  input  logic                  EX_MEM_RegWrite,
  output logic                  MEM_Stall,
  output logic                  MEM_WB_Valid,
  output logic [DATA_W-1:0]     MEM_WB_ALUResult,
  output logic [DATA_W-1:0]     MEM_WB_ReadData,
  output logic [REG_ADDR_W-1:0] MEM_WB_WriteReg,
  output logic                  MEM_WB_MemToReg,
  output logic                  MEM_WB_RegWrite,
  output logic                  MEM_WB_Misaligned
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(NBYTES);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [OFF_W-1:0]      off;
  logic [2:0]            off3;
  logic [IDX_W-1:0]      idx;
  int unsigned           off_bytes;
  int unsigned           acc_bytes;
  logic                  align_err;
  logic                  misaligned;
  logic                  memop;
  logic                  mem_we;
  logic [DATA_W-1:0]     rd_word;
  logic [DATA_W-1:0]     rd_shift;
  logic                  sign_bit;
  logic [DATA_W-1:0]     load_ext;
  logic [DATA_W-1:0]     st_shift;
  logic [DATA_W-1:0]     wr_word;

  logic                  valid_d;
  logic [DATA_W-1:0]     alu_d;
  logic [DATA_W-1:0]     rdata_d;
  logic [REG_ADDR_W-1:0] wreg_d;
  logic                  m2r_d;
  logic                  rw_d;
  logic                  mis_d;

  assign off       = EX_MEM_ALUResult[OFF_W-1:0];
  assign off3      = 3'(off);
  assign idx       = EX_MEM_ALUResult[IDX_W+OFF_W-1:OFF_W];
  assign off_bytes = 32'(off);
  assign acc_bytes = 32'd1 << EX_MEM_Size;

  // Alignment: the offset must be a multiple of the access size; doubleword needs a 64-bit path
  always_comb begin
    case (EX_MEM_Size)
      2'b00:   align_err = 1'b0;
      2'b01:   align_err = off3[0];
      2'b10:   align_err = |off3[1:0];
      default: align_err = (DATA_W == 32) || (|off3);
    endcase
  end

  assign misaligned = EX_MEM_Valid & (EX_MEM_MemRead | EX_MEM_MemWrite) & align_err;
  assign memop      = EX_MEM_Valid & (EX_MEM_MemRead | EX_MEM_MemWrite) & ~align_err;
  assign MEM_Stall  = rst & memop & (cnt_q != CNT_W'(MEM_LATENCY));
  assign mem_we     = rst & memop & EX_MEM_MemWrite & ~MEM_Stall;

  // Load lane select and extension; the array read is asynchronous so prior stores are visible
  assign rd_word  = mem_q[idx];
  assign rd_shift = rd_word >> {off, 3'b000};

  always_comb begin
    case (EX_MEM_Size)
      2'b00:   sign_bit = rd_shift[7];
      2'b01:   sign_bit = rd_shift[15];
      2'b10:   sign_bit = rd_shift[31];
      default: sign_bit = rd_shift[DATA_W-1];
    endcase
  end

  always_comb begin
    load_ext = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      load_ext[8*i +: 8] = (i < acc_bytes) ? rd_shift[8*i +: 8]
                                           : {8{sign_bit & ~EX_MEM_Unsigned}};
    end
  end

  // Store merge: replace only the addressed byte lanes of the current word
  assign st_shift = EX_MEM_ReadData2 << {off, 3'b000};

  always_comb begin
    wr_word = rd_word;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if ((i >= off_bytes) && (i < off_bytes + acc_bytes)) begin
        wr_word[8*i +: 8] = st_shift[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx] <= wr_word;
    end
  end

  // Next MEM/WB contents: bubble while stalling or for an empty slot, capture otherwise
  always_comb begin
    cnt_d   = cnt_q;
    valid_d = MEM_WB_Valid;
    alu_d   = MEM_WB_ALUResult;
    rdata_d = MEM_WB_ReadData;
    wreg_d  = MEM_WB_WriteReg;
    m2r_d   = MEM_WB_MemToReg;
    rw_d    = MEM_WB_RegWrite;
    mis_d   = MEM_WB_Misaligned;
    if (MEM_Stall) begin
      cnt_d   = cnt_q + CNT_W'(1);
      valid_d = 1'b0;
      m2r_d   = 1'b0;
      rw_d    = 1'b0;
      mis_d   = 1'b0;
    end else begin
      cnt_d = '0;
      if (EX_MEM_Valid) begin
        valid_d = 1'b1;
        alu_d   = EX_MEM_ALUResult;
        wreg_d  = EX_MEM_WriteReg;
        m2r_d   = EX_MEM_MemToReg;
        rw_d    = EX_MEM_RegWrite & ~misaligned;
        mis_d   = misaligned;
        rdata_d = (memop & EX_MEM_MemRead & ~EX_MEM_MemWrite) ? load_ext : '0;
      end else begin
        valid_d = 1'b0;
        m2r_d   = 1'b0;
        rw_d    = 1'b0;
        mis_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q             <= '0;
      MEM_WB_Valid      <= 1'b0;
      MEM_WB_ALUResult  <= '0;
      MEM_WB_ReadData   <= '0;
      MEM_WB_WriteReg   <= '0;
      MEM_WB_MemToReg   <= 1'b0;
      MEM_WB_RegWrite   <= 1'b0;
      MEM_WB_Misaligned <= 1'b0;
    end else begin
      cnt_q             <= cnt_d;
      MEM_WB_Valid      <= valid_d;
      MEM_WB_ALUResult  <= alu_d;
      MEM_WB_ReadData   <= rdata_d;
      MEM_WB_WriteReg   <= wreg_d;
      MEM_WB_MemToReg   <= m2r_d;
      MEM_WB_RegWrite   <= rw_d;
      MEM_WB_Misaligned <= mis_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_sized.sv
// Scoreboard bench for mem_stage_sized (DATA_W=32, DEPTH=64, MEM_LATENCY=2):
// a byte-array reference model predicts each MEM/WB capture and the stall length.
module tb_mem_stage_sized;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned MB    = DEPTH * 4;

  typedef struct {
    logic        v;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  dst;
    logic        ld;
    logic        st;
    logic [1:0]  size;
    logic        uns;
    logic        m2r;
    logic        rw;
  } instr_t;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  dst;
    logic        m2r;
    logic        rw;
    logic        mis;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_alu;
  logic [31:0] ex_rd2;
  logic [4:0]  ex_wreg;
  logic        ex_mread;
  logic        ex_mwrite;
  logic [1:0]  ex_size;
  logic        ex_uns;
  logic        ex_m2r;
  logic        ex_rw;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_alu;
  logic [31:0] wb_rdata;
  logic [4:0]  wb_wreg;
  logic        wb_m2r;
  logic        wb_rw;
  logic        wb_mis;

  int   n_cmp;
  int   n_fail;
  exp_t exp_q[$];
  logic [7:0] mem_m [MB];

  mem_stage_sized #(
    .DATA_W(32), .DEPTH(DEPTH), .REG_ADDR_W(5), .MEM_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .EX_MEM_Valid(ex_valid), .EX_MEM_ALUResult(ex_alu), .EX_MEM_ReadData2(ex_rd2),
    .EX_MEM_WriteReg(ex_wreg), .EX_MEM_MemRead(ex_mread), .EX_MEM_MemWrite(ex_mwrite),
    .EX_MEM_Size(ex_size), .EX_MEM_Unsigned(ex_uns), .EX_MEM_MemToReg(ex_m2r),
    .EX_MEM_RegWrite(ex_rw), .MEM_Stall(stall),
    .MEM_WB_Valid(wb_valid), .MEM_WB_ALUResult(wb_alu), .MEM_WB_ReadData(wb_rdata),
    .MEM_WB_WriteReg(wb_wreg), .MEM_WB_MemToReg(wb_m2r), .MEM_WB_RegWrite(wb_rw),
    .MEM_WB_Misaligned(wb_mis)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic instr_t mk(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                                input logic [4:0] dst, input logic ld, input logic st,
                                input logic [1:0] size, input logic uns, input logic m2r,
                                input logic rw);
    instr_t t;
    t.v = v; t.alu = alu; t.wd = wd; t.dst = dst; t.ld = ld; t.st = st;
    t.size = size; t.uns = uns; t.m2r = m2r; t.rw = rw;
    return t;
  endfunction

  // Reference model: byte-addressed little-endian memory, wrapping at MB bytes
  task automatic model(input instr_t in, output exp_t e, output int stalls_exp);
    int unsigned nb;
    int unsigned off;
    int unsigned base;
    logic        access;
    logic        mis;
    logic        memop;
    logic [63:0] val;
    nb     = 32'd1 << in.size;
    off    = 32'(in.alu[1:0]);
    access = in.v && (in.ld || in.st);
    mis    = access && ((in.size == 2'd3) || ((off % nb) != 0));
    memop  = access && !mis;
    stalls_exp = memop ? int'(LAT) : 0;
    e.alu   = in.alu;
    e.dst   = in.dst;
    e.m2r   = in.m2r;
    e.rw    = in.rw && !mis;
    e.mis   = mis;
    e.rdata = 32'd0;
    base    = 32'(in.alu[7:0]);
    if (memop && in.st) begin
      for (int unsigned b = 0; b < nb; b++) mem_m[(base + b) % MB] = in.wd[8*b +: 8];
    end else if (memop && in.ld) begin
      val = 64'd0;
      for (int unsigned b = 0; b < nb; b++) val = val | (64'(mem_m[(base + b) % MB]) << (8 * b));
      if (!in.uns && val[8*nb-1]) val = val | ~((64'd1 << (8 * nb)) - 64'd1);
      e.rdata = val[31:0];
    end
  endtask

  task automatic drive(input instr_t in);
    ex_valid = in.v;  ex_alu = in.alu; ex_rd2 = in.wd;  ex_wreg = in.dst;
    ex_mread = in.ld; ex_mwrite = in.st; ex_size = in.size; ex_uns = in.uns;
    ex_m2r = in.m2r;  ex_rw = in.rw;
  endtask

  task automatic idle();
    @(negedge clk);
    drive(mk(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
  endtask

  // Present one instruction, hold it through any stall, then queue the predicted capture
  task automatic issue(input instr_t in);
    exp_t e;
    int   se;
    int   st;
    @(negedge clk);
    drive(in);
    #1;
    st = 0;
    while (stall && st < 10) begin
      @(negedge clk);
      #1;
      st++;
    end
    model(in, e, se);
    if (in.v) exp_q.push_back(e);
    chk("stall_cycles", 64'(st), 64'(se));
  endtask

  function automatic instr_t rnd();
    instr_t t;
    int unsigned k;
    k = $urandom_range(0, 9);
    t = mk(1'b1, $urandom, $urandom, 5'($urandom), 1'b0, 1'b0, 2'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom), 1'($urandom));
    if (k == 0) begin
      t.v = 1'b0; t.ld = 1'($urandom); t.st = 1'($urandom);
    end else if (k <= 2) begin
      t.size = 2'd0;
    end else begin
      t.ld = (k <= 5) || (k == 9);
      t.st = (k >= 6);
    end
    if ($urandom_range(0, 9) < 7) t.alu = t.alu & ~((32'd1 << t.size) - 32'd1);
    return t;
  endfunction

  // Monitor: pop and compare on every valid capture; bubbles must carry no side effects
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 64'(wb_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("alu_result", 64'(wb_alu), 64'(e.alu));
          chk("read_data", 64'(wb_rdata), 64'(e.rdata));
          chk("write_reg", 64'(wb_wreg), 64'(e.dst));
          chk("mem_to_reg", 64'(wb_m2r), 64'(e.m2r));
          chk("reg_write", 64'(wb_rw), 64'(e.rw));
          chk("misaligned", 64'(wb_mis), 64'(e.mis));
        end
      end else begin
        chk("bubble_flags", 64'({wb_rw, wb_m2r, wb_mis}), 64'd0);
      end
    end
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    drive(mk(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
    #1 rst = 1'b0;
    #2;
    chk("reset_outputs", 64'({wb_valid, wb_rw, wb_m2r, wb_mis, stall}), 64'd0);
    chk("reset_data", 64'({wb_alu, wb_rdata}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed sequence
    issue(mk(1, 32'h10, 32'hABCD1234, 5'd0, 0, 1, 2'd2, 0, 0, 0));
    issue(mk(1, 32'h10, 32'h0,        5'd3, 1, 0, 2'd2, 0, 1, 1));
    issue(mk(1, 32'h11, 32'h000000F0, 5'd0, 0, 1, 2'd0, 0, 0, 0));
    issue(mk(1, 32'h11, 32'h0,        5'd4, 1, 0, 2'd0, 0, 1, 1));
    issue(mk(1, 32'h11, 32'h0,        5'd5, 1, 0, 2'd0, 1, 1, 1));
    issue(mk(1, 32'h10, 32'h0,        5'd6, 1, 0, 2'd2, 0, 1, 1));
    issue(mk(1, 32'h12, 32'h0,        5'd7, 1, 0, 2'd1, 0, 1, 1));
    issue(mk(1, 32'h13, 32'h0,        5'd8, 1, 0, 2'd1, 0, 1, 1));
    issue(mk(1, 32'h10, 32'h11111111, 5'd0, 0, 1, 2'd3, 0, 0, 0));
    issue(mk(0, 32'h10, 32'h22222222, 5'd0, 0, 1, 2'd2, 0, 0, 0));
    issue(mk(1, 32'h10, 32'h0,        5'd9, 1, 0, 2'd2, 0, 1, 1));
    issue(mk(1, 32'h12345678, 32'h0,  5'd7, 0, 0, 2'd0, 0, 0, 1));
    issue(mk(1, 32'h310, 32'h0,       5'd10, 1, 1, 2'd2, 0, 1, 1));

    // Asynchronous reset clears MEM/WB without a clock edge
    issue(mk(1, 32'h10, 32'h0, 5'd11, 1, 0, 2'd2, 0, 1, 1));
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_flags", 64'({wb_valid, wb_rw, wb_m2r, wb_mis, stall}), 64'd0);
    chk("async_reset_data", 64'({wb_alu, wb_rdata, 27'd0, wb_wreg}), 64'd0);
    idle();
    @(negedge clk);
    rst = 1'b1;

    // Reset in the first stall cycle discards the pending store
    @(negedge clk);
    drive(mk(1, 32'h10, 32'h55555555, 5'd0, 0, 1, 2'd2, 0, 0, 0));
    #1;
    chk("stall_before_reset", 64'(stall), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("stall_in_reset", 64'({stall, wb_valid}), 64'd0);
    idle();
    @(negedge clk);
    rst = 1'b1;
    issue(mk(1, 32'h10, 32'h0, 5'd12, 1, 0, 2'd2, 0, 1, 1));

    // Fill every word (upper address bits random to exercise wrap), then random traffic
    for (int unsigned w = 0; w < DEPTH; w++) begin
      issue(mk(1, {$urandom_range(0, 16777215), 8'(w * 4)} , $urandom, 5'd0, 0, 1, 2'd2, 0, 0, 0));
    end
    for (int n = 0; n < 300; n++) issue(rnd());

    idle();
    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
